// File: rtl/pc_if_stage.sv
// Instruction-fetch stage: 11-bit PC register, PC+1 generation and the IF/ID register.
// Optional performance counters are built only when PC_IF_PERF_CNT_EN is defined.
module pc_if_stage #(
  parameter logic [10:0] RESET_PC  = 11'd0,
  parameter logic [31:0] NOP_INSTR = 32'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] pc_siguiente,
  output logic [10:0] pc_mas_uno,
  input  logic        stall,
  input  logic        flush,
  output logic [10:0] imem_addr,
  input  logic [31:0] imem_dato,
  input  logic        imem_listo,
  output logic [31:0] instr_id,
  output logic [10:0] pc_id,
  output logic        valido_id,
  output logic [15:0] cnt_fetch,
  output logic [15:0] cnt_espera
);

  // Handshake: imem_dato is consumed on a rising edge only when imem_listo=1,
  // flush=0 and stall=0; otherwise the memory must keep the word for imem_addr.
  typedef enum logic [1:0] {
    ACT_FETCH = 2'd0,
    ACT_FLUSH = 2'd1,
    ACT_HOLD  = 2'd2,
    ACT_WAIT  = 2'd3
  } act_t;

  logic [10:0] pc;
  act_t        act;

  assign pc_mas_uno = pc + 11'd1;
  assign imem_addr  = pc;

  always_comb begin
    act = ACT_FETCH;
    if (flush)           act = ACT_FLUSH;
    else if (stall)      act = ACT_HOLD;
    else if (!imem_listo) act = ACT_WAIT;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc        <= RESET_PC;
      instr_id  <= NOP_INSTR;
      pc_id     <= 11'd0;
      valido_id <= 1'b0;
    end else begin
      case (act)
        ACT_FLUSH: begin
          pc        <= pc_siguiente;
          instr_id  <= NOP_INSTR;
          pc_id     <= 11'd0;
          valido_id <= 1'b0;
        end
        ACT_HOLD: begin
          pc        <= pc;
          instr_id  <= instr_id;
          pc_id     <= pc_id;
          valido_id <= valido_id;
        end
        ACT_WAIT: begin
          // Address stays put so the memory can finish the same fetch.
          pc        <= pc;
          instr_id  <= NOP_INSTR;
          pc_id     <= 11'd0;
          valido_id <= 1'b0;
        end
        default: begin
          pc        <= pc_siguiente;
          instr_id  <= imem_dato;
          pc_id     <= pc_mas_uno;
          valido_id <= 1'b1;
        end
      endcase
    end
  end

`ifdef PC_IF_PERF_CNT_EN
  logic [15:0] fetch_q;
  logic [15:0] espera_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_q  <= 16'd0;
      espera_q <= 16'd0;
    end else begin
      if (act == ACT_FETCH && fetch_q != 16'hFFFF)
        fetch_q <= fetch_q + 16'd1;
      if ((act == ACT_HOLD || act == ACT_WAIT) && espera_q != 16'hFFFF)
        espera_q <= espera_q + 16'd1;
    end
  end

  assign cnt_fetch  = fetch_q;
  assign cnt_espera = espera_q;
`else
  assign cnt_fetch  = 16'd0;
  assign cnt_espera = 16'd0;
`endif

endmodule

// File: tb/tb_pc_if_stage.sv
// Directed bench for pc_if_stage: reset, stall, memory wait, flush, wrap and counters.
module tb_pc_if_stage;

  logic        clk;
  logic        reset_n;
  logic [10:0] pc_siguiente;
  logic [10:0] pc_mas_uno;
  logic        stall;
  logic        flush;
  logic [10:0] imem_addr;
  logic [31:0] imem_dato;
  logic        imem_listo;
  logic [31:0] instr_id;
  logic [10:0] pc_id;
  logic        valido_id;
  logic [15:0] cnt_fetch;
  logic [15:0] cnt_espera;

  logic        use_redirect;
  logic [10:0] redirect_pc;

  int checks;
  int errors;

  pc_if_stage dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pc_siguiente (pc_siguiente),
    .pc_mas_uno   (pc_mas_uno),
    .stall        (stall),
    .flush        (flush),
    .imem_addr    (imem_addr),
    .imem_dato    (imem_dato),
    .imem_listo   (imem_listo),
    .instr_id     (instr_id),
    .pc_id        (pc_id),
    .valido_id    (valido_id),
    .cnt_fetch    (cnt_fetch),
    .cnt_espera   (cnt_espera)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: content is a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [10:0] a);
    return {a, ~a, 10'h2A5};
  endfunction

  assign imem_dato    = mem_word(imem_addr);
  assign pc_siguiente = use_redirect ? redirect_pc : pc_mas_uno;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_if(input string tag, input logic [10:0] addr,
                          input logic [31:0] instr, input logic [10:0] pcid,
                          input logic v);
    check({tag, ".addr"},  {21'd0, imem_addr}, {21'd0, addr});
    check({tag, ".instr"}, instr_id, instr);
    check({tag, ".pc_id"}, {21'd0, pc_id}, {21'd0, pcid});
    check({tag, ".valid"}, {31'd0, valido_id}, {31'd0, v});
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset_n      = 1'b0;
    stall        = 1'b0;
    flush        = 1'b0;
    imem_listo   = 1'b1;
    use_redirect = 1'b0;
    redirect_pc  = 11'd0;

    // Reset state
    tick();
    tick();
    check_if("reset", 11'd0, 32'd0, 11'd0, 1'b0);
    check("reset.pc_mas_uno", {21'd0, pc_mas_uno}, 32'd1);
    check("reset.cnt_fetch",  {16'd0, cnt_fetch},  32'd0);
    check("reset.cnt_espera", {16'd0, cnt_espera}, 32'd0);
    reset_n = 1'b1;

    // Sequential fetch from RESET_PC
    tick(); check_if("seq1", 11'd1, mem_word(11'd0), 11'd1, 1'b1);
    tick(); check_if("seq2", 11'd2, mem_word(11'd1), 11'd2, 1'b1);
    tick(); check_if("seq3", 11'd3, mem_word(11'd2), 11'd3, 1'b1);
    tick(); check_if("seq4", 11'd4, mem_word(11'd3), 11'd4, 1'b1);
    tick(); check_if("seq5", 11'd5, mem_word(11'd4), 11'd5, 1'b1);

    // Stall for 3 cycles at PC=5
    stall = 1'b1;
    tick(); check_if("stall1", 11'd5, mem_word(11'd4), 11'd5, 1'b1);
    tick(); check_if("stall2", 11'd5, mem_word(11'd4), 11'd5, 1'b1);
    tick(); check_if("stall3", 11'd5, mem_word(11'd4), 11'd5, 1'b1);
    stall = 1'b0;
    tick(); check_if("post_stall", 11'd6, mem_word(11'd5), 11'd6, 1'b1);
    tick(); check_if("seq7", 11'd7, mem_word(11'd6), 11'd7, 1'b1);
    tick(); tick();
    check_if("seq9", 11'd9, mem_word(11'd8), 11'd9, 1'b1);

    // Memory wait for 2 cycles at PC=9
    imem_listo = 1'b0;
    tick(); check_if("wait1", 11'd9, 32'd0, 11'd0, 1'b0);
    tick(); check_if("wait2", 11'd9, 32'd0, 11'd0, 1'b0);
    imem_listo = 1'b1;
    tick(); check_if("post_wait", 11'd10, mem_word(11'd9), 11'd10, 1'b1);
    tick(); tick();
    check_if("seq12", 11'd12, mem_word(11'd11), 11'd12, 1'b1);

    // Flush and stall together: flush wins
    flush = 1'b1; stall = 1'b1; use_redirect = 1'b1; redirect_pc = 11'd300;
    tick(); check_if("flush_stall", 11'd300, 32'd0, 11'd0, 1'b0);
    flush = 1'b0; stall = 1'b0; use_redirect = 1'b0;
    tick(); check_if("post_flush", 11'd301, mem_word(11'd300), 11'd301, 1'b1);

    // Wrap at 11'h7FF
    flush = 1'b1; use_redirect = 1'b1; redirect_pc = 11'h7FF;
    tick(); check_if("to_7ff", 11'h7FF, 32'd0, 11'd0, 1'b0);
    check("wrap.pc_mas_uno", {21'd0, pc_mas_uno}, 32'd0);
    flush = 1'b0; use_redirect = 1'b0;
    tick(); check_if("wrap", 11'd0, mem_word(11'h7FF), 11'd0, 1'b1);

    // Flush while the memory is not ready: redirect still happens
    flush = 1'b1; imem_listo = 1'b0; use_redirect = 1'b1; redirect_pc = 11'd50;
    tick(); check_if("flush_wait", 11'd50, 32'd0, 11'd0, 1'b0);
    flush = 1'b0; imem_listo = 1'b1; use_redirect = 1'b0;
    tick(); check_if("post_flush_wait", 11'd51, mem_word(11'd50), 11'd51, 1'b1);

    // Asynchronous reset between edges
    #3;
    reset_n = 1'b0;
    #1;
    check_if("async_reset", 11'd0, 32'd0, 11'd0, 1'b0);
    check("async_reset.cnt_fetch",  {16'd0, cnt_fetch},  32'd0);
    check("async_reset.cnt_espera", {16'd0, cnt_espera}, 32'd0);
    tick();
    reset_n = 1'b1;

    // 10 fetches, 4 stall cycles, 3 wait cycles
    for (int i = 0; i < 10; i++) tick();
    check_if("ten_fetch", 11'd10, mem_word(11'd9), 11'd10, 1'b1);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    stall = 1'b0; imem_listo = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    imem_listo = 1'b1;
    check("after_wait.addr", {21'd0, imem_addr}, 32'd10);
`ifdef PC_IF_PERF_CNT_EN
    check("perf.cnt_fetch",  {16'd0, cnt_fetch},  32'd10);
    check("perf.cnt_espera", {16'd0, cnt_espera}, 32'd7);
    for (int i = 0; i < 65540; i++) tick();
    check("sat.cnt_fetch",  {16'd0, cnt_fetch},  32'hFFFF);
    check("sat.cnt_espera", {16'd0, cnt_espera}, 32'd7);
`else
    check("nocnt.cnt_fetch",  {16'd0, cnt_fetch},  32'd0);
    check("nocnt.cnt_espera", {16'd0, cnt_espera}, 32'd0);
`endif

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
